// File: rtl/jk_cmd_sequencer.sv
// Command sequencer driving J/K of a downstream JK flop and checking its q feedback.
// Optional JKSEQ_ERR_HALT_EN: a failed check parks the FSM in HALT until rst.
module jk_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [HOLD_W-1:0]        cmd_hold,
    output logic                     J,
    output logic                     K,
    input  logic                     q,
    output logic                     done,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 2 + HOLD_W;

`ifdef JKSEQ_ERR_HALT_EN
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK} state_t;
`endif

    function automatic logic f_expected(input logic [1:0] op, input logic q_prev,
                                        input logic n_lsb);
        logic res;
        case (op)
            2'b10:   res = 1'b1;
            2'b01:   res = 1'b0;
            2'b11:   res = q_prev ^ n_lsb;
            default: res = q_prev;
        endcase
        return res;
    endfunction

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;

    state_t            r_state;
    state_t            w_next;
    logic [HOLD_W-1:0] r_cnt;
    logic [1:0]        r_op;
    logic              r_q_prev;
    logic              r_n_lsb;
    logic              r_exp;
    logic              r_j;
    logic              r_k;
    logic              r_err;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drive_end;
    logic              w_mismatch;
    logic [EW-1:0]     w_head;
    logic [1:0]        w_head_op;
    logic [HOLD_W-1:0] w_head_hold;
    logic [HOLD_W-1:0] w_load_n;

    assign w_full      = (r_level == LW'(DEPTH));
    assign w_empty     = (r_level == '0);
    assign cmd_ready   = !w_full && !rst;
    assign w_push      = cmd_valid && cmd_ready;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_op   = w_head[EW-1 -: 2];
    assign w_head_hold = w_head[HOLD_W-1:0];
    assign w_load_n    = (w_head_hold == '0) ? HOLD_W'(1) : w_head_hold;

    // FIFO stage: pushes are independent of the FSM; pops come only from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {cmd_op, cmd_hold};
    end

    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_drive_end = 1'b0;
        w_mismatch  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_cnt == HOLD_W'(1)) begin
                    w_drive_end = 1'b1;
                    w_next      = S_CHECK;
                end
            end
            S_CHECK: begin
                w_mismatch = (q != r_exp);
`ifdef JKSEQ_ERR_HALT_EN
                w_next     = w_mismatch ? S_HALT : S_IDLE;
`else
                w_next     = S_IDLE;
`endif
            end
`ifdef JKSEQ_ERR_HALT_EN
            S_HALT: w_next = S_HALT;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Control stage: state, J/K drive and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_j <= w_head_op[1];
                r_k <= w_head_op[0];
            end else if (w_drive_end) begin
                r_j <= 1'b0;
                r_k <= 1'b0;
            end
            if (w_mismatch) r_err <= 1'b1;
        end
    end

    // Command data stage: hold counter and expected-q bookkeeping
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_cnt    <= w_load_n;
            r_op     <= w_head_op;
            r_q_prev <= q;
            r_n_lsb  <= w_load_n[0];
        end else if (r_state == S_DRIVE && !w_drive_end) begin
            r_cnt <= r_cnt - HOLD_W'(1);
        end
        if (w_drive_end) r_exp <= f_expected(r_op, r_q_prev, r_n_lsb);
    end

    assign J     = r_j;
    assign K     = r_k;
    assign err   = r_err;
    assign done  = (r_state == S_CHECK) && !rst;
    assign busy  = !rst && ((r_state != S_IDLE) || !w_empty);
    assign level = r_level;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with an ideal JK flop model on the J/K/q loop.
module tb_jk_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_hold;
    logic       J;
    logic       K;
    logic       q;
    logic       done;
    logic       err;
    logic       busy;
    logic [2:0] level;

    logic       model_q = 1'b0;
    logic       stuck = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(.DEPTH(4), .HOLD_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_hold(cmd_hold), .J(J), .K(K), .q(q),
        .done(done), .err(err), .busy(busy), .level(level)
    );

    assign q = stuck ? 1'b0 : model_q;

    always @(posedge clk) begin
        case ({J, K})
            2'b01:   model_q <= 1'b0;
            2'b10:   model_q <= 1'b1;
            2'b11:   model_q <= ~model_q;
            default: model_q <= model_q;
        endcase
    end

    // Negedge monitor: counts done pulses and logs J/K at each drive start
    logic       mon_clr = 1'b0;
    int         done_cnt = 0;
    int         start_cnt = 0;
    logic       prev_jk = 1'b0;
    logic [1:0] jk_log [8];

    always @(negedge clk) begin
        if (mon_clr) begin
            done_cnt  <= 0;
            start_cnt <= 0;
            prev_jk   <= 1'b0;
        end else begin
            prev_jk <= J | K;
            if (done) done_cnt <= done_cnt + 1;
            if ((J | K) && !prev_jk && start_cnt < 8) begin
                jk_log[start_cnt[2:0]] <= {J, K};
                start_cnt <= start_cnt + 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    // Push one command into an idle sequencer and follow it to completion
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] hold, input int n,
                           input logic exp_q, input logic exp_err);
        int   jk_cycles;
        int   done_at;
        logic seen;
        logic q_at;
        jk_cycles = 0;
        done_at   = 0;
        seen      = 1'b0;
        q_at      = 1'b0;
        cmd_op    = op;
        cmd_hold  = hold;
        cmd_valid = 1'b1;
        check("push_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("level_after_push", level, 1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                check("first_J", J, op[1]);
                check("first_K", K, op[0]);
            end
            if (J | K) jk_cycles++;
            if (done) begin
                seen    = 1'b1;
                done_at = k;
                q_at    = q;
                break;
            end
        end
        check("done_seen", seen, 1);
        check("jk_cycles", jk_cycles, (op == 2'b00) ? 0 : n);
        check("done_latency", done_at, n + 1);
        check("q_at_check", q_at, exp_q);
        tick();
        check("done_one_cycle", done, 0);
        check("err_after", err, exp_err);
        check("busy_after", busy, 0);
    endtask

    logic [1:0] t4_op   [5];
    logic [3:0] t4_hold [5];

    initial begin
        logic acc;
        logic reached;
        t4_op   = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
        t4_hold = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_hold  = 4'd0;

        // Reset state
        tick();
        tick();
        check("rst_level", level, 0);
        check("rst_J", J, 0);
        check("rst_K", K, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", cmd_ready, 1);

        // 1: set, hold=1, q 0 -> 1
        run_cmd(2'b10, 4'd1, 1, 1'b1, 1'b0);
        // 2: toggle, hold=3, q 1 -> 0
        run_cmd(2'b11, 4'd3, 3, 1'b0, 1'b0);
        // 3: toggle, hold=0 acts as 1, q 0 -> 1
        run_cmd(2'b11, 4'd0, 1, 1'b1, 1'b0);

        // 4: long hold command, then five queued behind it
        clear_mon();
        cmd_op    = 2'b00;
        cmd_hold  = 4'd10;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t4_popped_level", level, 0);
        check("t4_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            cmd_op    = t4_op[i];
            cmd_hold  = t4_hold[i];
            cmd_valid = 1'b1;
            if (i == 4) begin
                check("t4_full_level", level, 4);
                check("t4_full_ready", cmd_ready, 0);
            end
            acc = 1'b0;
            for (int w = 0; w < 40; w++) begin
                if (cmd_ready) begin
                    acc = 1'b1;
                    tick();
                    break;
                end
                tick();
            end
            check("t4_accepted", acc, 1);
        end
        cmd_valid = 1'b0;
        check("t4_level_after_fifth", level, 4);
        reached = 1'b0;
        for (int w = 0; w < 200; w++) begin
            if (!busy) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        check("t4_drained", reached, 1);
        check("t4_starts", start_cnt, 5);
        for (int i = 0; i < 5; i++) check("t4_order", jk_log[i], t4_op[i]);
        check("t4_dones", done_cnt, 6);
        check("t4_err", err, 0);
        check("t4_q", q, 0);

        // 5: q stuck at 0, set must mismatch; a reset command queued behind it
        stuck = 1'b1;
        clear_mon();
        cmd_op    = 2'b10;
        cmd_hold  = 4'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_op    = 2'b01;
        cmd_hold  = 4'd1;
        tick();
        cmd_valid = 1'b0;
        reached = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (done) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        check("t5_done_seen", reached, 1);
        tick();
        check("t5_err_set", err, 1);
`ifdef JKSEQ_ERR_HALT_EN
        for (int w = 0; w < 10; w++) begin
            tick();
            check("t5_halt_J", J, 0);
            check("t5_halt_K", K, 0);
        end
        check("t5_halt_level", level, 1);
        check("t5_halt_busy", busy, 1);
        check("t5_halt_dones", done_cnt, 1);
`else
        reached = 1'b0;
        for (int w = 0; w < 40; w++) begin
            if (!busy) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        check("t5_drained", reached, 1);
        check("t5_dones", done_cnt, 2);
`endif
        check("t5_err_sticky", err, 1);
        stuck = 1'b0;

        // 6: rst clears err, then rst during a long toggle with two queued
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6_err_cleared", err, 0);
        check("t6_level_cleared", level, 0);
        cmd_op    = 2'b11;
        cmd_hold  = 4'd8;
        cmd_valid = 1'b1;
        tick();
        cmd_op    = 2'b01;
        cmd_hold  = 4'd1;
        tick();
        cmd_op    = 2'b10;
        cmd_hold  = 4'd2;
        tick();
        cmd_valid = 1'b0;
        check("t6_queued", level, 2);
        check("t6_J_driving", J, 1);
        check("t6_K_driving", K, 1);
        clear_mon();
        rst = 1'b1;
        tick();
        check("t6_rst_J", J, 0);
        check("t6_rst_K", K, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        check("t6_ready_after", cmd_ready, 1);
        tick();
        tick();
        check("t6_idle_busy", busy, 0);
        check("t6_no_done", done_cnt, 0);
        run_cmd(2'b10, 4'd2, 2, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream driver for the JKflop stage.
- Accepts set/reset/hold/toggle commands over a valid/ready handshake and buffers them in a small FIFO.
- Converts each command into registered J/K levels held for a programmed number of clocks.
- Reads back the flop's q and checks it against the expected result, flagging done and err.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- HOLD_W, 4, width of the per-command hold count.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full && !rst.
- cmd_op  input  2  00 hold (J=0,K=0), 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1).
- cmd_hold  input  HOLD_W  clocks to drive J/K; 0 is treated as 1.
- J  output  1  registered J drive to JKflop.
- K  output  1  registered K drive to JKflop.
- q  input  1  feedback from JKflop q.
- done  output  1  one-cycle pulse when a command's check completes.
- err  output  1  sticky mismatch flag; cleared only by rst.
- busy  output  1  high when state != IDLE or FIFO is non-empty.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: on a clk edge with rst=1, FIFO empties (level=0); state=IDLE; J=0, K=0, done=0, err=0; busy=0 and cmd_ready=0 while rst is high.
- Push: when cmd_valid && cmd_ready, {cmd_op, cmd_hold} is written. No push when full, even if a pop occurs in the same cycle.
- Pop timing: a push into an empty FIFO is not popped in the same cycle; the entry is visible the next cycle.
- FIFO pointers: wrap modulo DEPTH.
- IDLE: if the FIFO is non-empty, at the edge:
  - pop one entry;
  - load J/K from cmd_op;
  - load cnt = max(cmd_hold, 1);
  - capture q_prev = q;
  - go to DRIVE.
- DRIVE: J/K held constant.
  - If cnt==1 at the edge: J<=0, K<=0, go to CHECK. J/K are therefore high for exactly n = max(cmd_hold, 1) cycles.
  - Otherwise cnt decrements.
- Expected q, computed in DRIVE:
  - set -> 1
  - reset -> 0
  - hold -> q_prev
  - toggle -> q_prev ^ n[0]
- CHECK: one cycle. done=1 for this cycle. If q != expected, err<=1 at the edge. Then go to IDLE.
- Latency per command: 1 (pop) + n (drive) + 1 (check) cycles. Minimum 3 cycles per command; no overlap between commands.
- Reset mid-command: the in-flight command and the FIFO contents are discarded; J=K=0 at the same edge; no done pulse.
- The FIFO accepts pushes in every state, independent of the FSM.

Optional Feature:
- Macro: JKSEQ_ERR_HALT_EN.
- Defined: a mismatch in CHECK moves the FSM to a HALT state instead of IDLE.
  - HALT holds J=K=0 and pops nothing.
  - busy stays 1; the FIFO still accepts until full.
  - Only rst exits HALT.
- Undefined: a mismatch only sets err, and sequencing continues. There is no HALT state.

Test Plan:
1. Reset, then push set (op=10, hold=1) with an ideal JKflop model attached (q starts at 0).
   -> J=1 for 1 cycle; q=1 in CHECK; done pulses once; err=0.
2. From q=1, push toggle (op=11, hold=3).
   -> J=K=1 for 3 cycles; expected=0; q=0 at CHECK; err=0.
3. Push toggle with hold=0.
   -> treated as n=1; J=K=1 for exactly 1 cycle; q inverts.
4. Push 5 commands back-to-back while the FSM is busy with DEPTH=4.
   -> cmd_ready drops when level=4; the 5th is accepted once a pop frees a slot; all execute in order, each with a done pulse.
5. Force q stuck at 0 and push set (op=10).
   -> done pulses and err=1 stays set.
   -> With JKSEQ_ERR_HALT_EN: the following queued command is never driven (J=K=0, level unchanged) until rst.
6. Assert rst during DRIVE of a hold=8 toggle with 2 entries queued.
   -> next edge: J=K=0, level=0, no done, state IDLE; after rst, cmd_ready=1.
